fifo_stream_reader: RTL and testbench

// - Read-side consumer for fifo_async_circular (read_clk domain): pops first-word-fall-through

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/stream_skid_buf.sv | 64 ++++++
 rtl/fifo_stream_reader.sv | 94 +++++++++
 tb/tb_fifo_stream_reader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types and helpers for the FIFO read-side stream logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_RUN    = 2'd1,
        RD_FINISH = 2'd2
    } rd_state_t;

    // Beat index needs at least one bit even when a burst is a single beat.
    function automatic int beat_idx_width(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_skid_buf.sv
// ============================================================================
//  Module      : stream_skid_buf
//  Description : Two-entry FIFO-ordered buffer; head entry drives the output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_skid_buf #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_push_data;
                    else                 r_tail <= i_push_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy holds; new word lands behind whatever remains.
                    if (r_count == 2'd1) begin
                        r_head <= i_push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// ============================================================================
//  Module      : fifo_stream_reader
//  Description : Pops an FWFT FIFO into a valid/ready stream framed in bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic             read_clk,
    input  logic             rst_in,
    input  logic             enable_in,
    input  logic             empty_in,
    input  logic [WIDTH-1:0] data_read_in,
    output logic             read_out,
    output logic             m_valid_out,
    output logic [WIDTH-1:0] m_data_out,
    output logic             m_last_out,
    input  logic             m_ready_in,
    output logic             busy_out,
    output logic [CNT_W-1:0] beat_cnt_out
);

    localparam int                 c_IDX_W    = beat_idx_width(BURST_LEN);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(BURST_LEN - 1);

    rd_state_t          r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [1:0]         w_count;
    logic [WIDTH:0]     w_head;
    logic               w_stop_now;
    logic               w_idx_last;
    logic               w_accept;

    assign w_idx_last = (r_idx == c_LAST_IDX);
    // Dropping enable exactly on a burst boundary must not start a new burst.
    assign w_stop_now = (r_state == RD_RUN) && !enable_in && (r_idx == '0);
    assign read_out   = (r_state != RD_IDLE) && !empty_in && (w_count != 2'd2)
                        && !rst_in && !w_stop_now;
    assign w_accept   = m_valid_out && m_ready_in;

    always_ff @(posedge read_clk) begin
        if (rst_in) begin
            r_state    <= RD_IDLE;
            r_idx      <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (read_out) r_idx <= w_idx_last ? '0 : r_idx + c_IDX_W'(1);
            if (w_accept) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            case (r_state)
                RD_IDLE: begin
                    if (enable_in) r_state <= RD_RUN;
                end
                RD_RUN: begin
                    if (!enable_in) begin
                        if (r_idx == '0 || (read_out && w_idx_last)) r_state <= RD_IDLE;
                        else                                         r_state <= RD_FINISH;
                    end
                end
                RD_FINISH: begin
                    if (read_out && w_idx_last) r_state <= RD_IDLE;
                end
                default: r_state <= RD_IDLE;
            endcase
        end
    end

    stream_skid_buf #(
        .WIDTH (WIDTH + 1)
    ) u_skid (
        .clk         (read_clk),
        .rst         (rst_in),
        .i_push      (read_out),
        .i_push_data ({w_idx_last, data_read_in}),
        .i_pop       (m_ready_in),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign m_valid_out  = (w_count != 2'd0);
    assign m_last_out   = w_head[WIDTH];
    assign m_data_out   = w_head[WIDTH-1:0];
    assign busy_out     = (r_state != RD_IDLE) || (w_count != 2'd0);
    assign beat_cnt_out = r_beat_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ============================================================================
//  Module      : tb_fifo_stream_reader
//  Description : Directed bench with an FWFT FIFO model and beat scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_stream_reader;

    localparam int BURST_LEN = 4;

    logic        read_clk = 1'b0;
    logic        rst_in = 1'b1, enable_in = 1'b0, empty_in = 1'b1, m_ready_in = 1'b0;
    logic [7:0]  data_read_in = 8'h00;
    logic        read_out, m_valid_out, m_last_out, busy_out;
    logic [7:0]  m_data_out;
    logic [15:0] beat_cnt_out;
    logic        w_read_out, w_valid, w_last, w_busy;
    logic [7:0]  w_data;
    logic [3:0]  w_cnt;

    always #5 read_clk = ~read_clk;

    fifo_stream_reader #(.WIDTH(8), .BURST_LEN(BURST_LEN), .CNT_W(16)) u_dut (
        .read_clk(read_clk), .rst_in(rst_in), .enable_in(enable_in), .empty_in(empty_in),
        .data_read_in(data_read_in), .read_out(read_out), .m_valid_out(m_valid_out),
        .m_data_out(m_data_out), .m_last_out(m_last_out), .m_ready_in(m_ready_in),
        .busy_out(busy_out), .beat_cnt_out(beat_cnt_out));

    fifo_stream_reader #(.WIDTH(8), .BURST_LEN(BURST_LEN), .CNT_W(4)) u_wrap (
        .read_clk(read_clk), .rst_in(rst_in), .enable_in(enable_in), .empty_in(empty_in),
        .data_read_in(data_read_in), .read_out(w_read_out), .m_valid_out(w_valid),
        .m_data_out(w_data), .m_last_out(w_last), .m_ready_in(m_ready_in),
        .busy_out(w_busy), .beat_cnt_out(w_cnt));

    typedef struct {
        logic        en, rdy;
        logic        exp_read, exp_valid;
        logic [7:0]  exp_data;
        logic        exp_last;
        logic [15:0] exp_cnt;
        logic        exp_busy;
    } vec_t;

    vec_t        vecs [12];
    logic [7:0]  fifo_q [$];
    logic [7:0]  inflight [$];
    int          n_checks = 0, n_fail = 0;
    int          pos = 0, acc = 0, rd_count = 0, cyc = 0;
    bit          gap_mode = 1'b0;
    logic        s_rst, s_read, s_valid, s_last, s_empty, s_acc, s_busy;
    logic [7:0]  s_data;
    logic [15:0] s_cnt;
    logic [3:0]  s_wcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: cycle budget expired (cycle %0d)", name, cyc);
    endtask

    task automatic refresh();
        empty_in     = (gap_mode && cyc[1]) || (fifo_q.size() == 0);
        data_read_in = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic load(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + 8'(i));
        refresh();
    endtask

    task automatic sample();
        @(negedge read_clk);
        s_rst   = rst_in;
        s_read  = read_out;
        s_valid = m_valid_out;
        s_acc   = m_valid_out & m_ready_in;
        s_data  = m_data_out;
        s_last  = m_last_out;
        s_empty = empty_in;
        s_busy  = busy_out;
        s_cnt   = beat_cnt_out;
        s_wcnt  = w_cnt;
    endtask

    task automatic advance();
        @(posedge read_clk);
        #1;
        cyc++;
        if (s_rst) begin
            inflight.delete();
            pos = 0;
            acc = 0;
        end else begin
            if (s_acc) begin
                if (inflight.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_beat: got 0x%0h expected no beat", s_data);
                end else begin
                    check("beat_data", s_data, inflight.pop_front());
                    check("beat_last", s_last, pos == BURST_LEN - 1);
                    pos = (pos + 1) % BURST_LEN;
                    acc++;
                end
            end
            if (s_read) begin
                rd_count++;
                check("read_when_empty", s_empty, 1'b0);
                if (!s_empty && fifo_q.size() != 0) inflight.push_back(fifo_q.pop_front());
            end
        end
        refresh();
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while ((fifo_q.size() != 0 || inflight.size() != 0) && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) timeout(name);
    endtask

    initial begin
        int start;
        int guard;

        // en, rdy, read, valid, data, last, cnt, busy
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 16'd0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 16'd1, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 16'd2, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h13, 1'b1, 16'd3, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h14, 1'b0, 16'd4, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 16'd5, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h16, 1'b0, 16'd6, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h17, 1'b1, 16'd7, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd8, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd8, 1'b0};

        // Reset held with a non-empty FIFO
        load(8'h10, 8);
        rst_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("rst_read", s_read, 1'b0);
            advance();
        end
        rst_in = 1'b0;
        sample();
        check("rst_valid", s_valid, 1'b0);
        check("rst_cnt", s_cnt, 16'd0);
        check("rst_busy", s_busy, 1'b0);
        advance();

        // Streaming: cycle-exact vectors
        for (int i = 0; i < 12; i++) begin
            enable_in  = vecs[i].en;
            m_ready_in = vecs[i].rdy;
            sample();
            check($sformatf("vec%0d_read", i), s_read, vecs[i].exp_read);
            check($sformatf("vec%0d_valid", i), s_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_data", i), s_data, vecs[i].exp_data);
                check($sformatf("vec%0d_last", i), s_last, vecs[i].exp_last);
            end
            check($sformatf("vec%0d_cnt", i), s_cnt, vecs[i].exp_cnt);
            check($sformatf("vec%0d_busy", i), s_busy, vecs[i].exp_busy);
            advance();
        end

        // Backpressure: sink stalled for 5 cycles
        load(8'h20, 8);
        enable_in  = 1'b1;
        m_ready_in = 1'b0;
        tick();
        rd_count = 0;
        for (int i = 0; i < 5; i++) begin
            sample();
            if (s_valid) check("bp_hold", s_data, 8'h20);
            advance();
        end
        check("bp_reads", rd_count, 2);
        m_ready_in = 1'b1;
        drain("bp_drain");
        enable_in = 1'b0;
        tick();
        tick();
        sample();
        check("bp_idle_busy", s_busy, 1'b0);
        advance();

        // Stop at burst boundary: enable dropped after beat 1
        load(8'h30, 8);
        enable_in = 1'b1;
        rd_count  = 0;
        tick();
        tick();
        tick();
        enable_in = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("stop_reads", rd_count, 4);
        check("stop_left", fifo_q.size(), 4);
        sample();
        check("stop_read", s_read, 1'b0);
        check("stop_busy", s_busy, 1'b0);
        advance();

        // Empty gaps over 12 words (0x34..0x37 remain, plus 0x40..0x47)
        load(8'h40, 8);
        gap_mode  = 1'b1;
        enable_in = 1'b1;
        refresh();
        start = acc;
        guard = 0;
        while (acc - start < 12 && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) timeout("gap_beats");
        gap_mode  = 1'b0;
        enable_in = 1'b0;
        tick();
        tick();
        sample();
        check("gap_busy", s_busy, 1'b0);
        advance();

        // Mid-burst reset with words buffered
        load(8'h50, 8);
        enable_in = 1'b1;
        start = acc;
        guard = 0;
        while (acc - start < 2 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) timeout("mid_pre");
        m_ready_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
        sample();
        check("mid_rst_read", s_read, 1'b0);
        advance();
        rst_in = 1'b0;
        sample();
        check("mid_valid", s_valid, 1'b0);
        check("mid_cnt", s_cnt, 16'd0);
        advance();

        // Post-reset stream of 17 beats, also exercising counter wrap
        load(8'h60, 20);
        m_ready_in = 1'b1;
        guard = 0;
        while (acc < 17 && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) timeout("wrap_beats");
        m_ready_in = 1'b0;
        sample();
        check("cnt_17", s_cnt, 16'd17);
        check("wrap_cnt", s_wcnt, 4'd1);
        advance();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
